// File: rtl/fifo_tx_drain.sv
// fifo_tx_drain
// Drains words from an upstream FIFO and transmits each one as a serial
// frame: one start bit (0), WIDTH data bits LSB first, one stop bit (1).
// Every bit is held for CLKS_PER_BIT clock cycles.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   enable      permission to fetch a new word (looked at only while idle)
//   fifo_empty  upstream FIFO has no data (looked at only while idle)
//   fifo_re     one-cycle read strike to the FIFO, registered
//   fifo_data   FIFO read data, valid the cycle after fifo_re is sampled
//   tx          serial line, idle high, registered
//   busy        high whenever a fetch or frame is in progress, registered
//   words_sent  completed-frame counter, wraps modulo 256
//   dbg_state   current FSM state, for observation only
//
// Handshake: fifo_re is a pulse, not a level. The FIFO pops one word on
// the edge where it sees fifo_re=1 and presents it on fifo_data for the
// following cycle, which is exactly the cycle this block spends in LOAD.
module fifo_tx_drain #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_re,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             tx,
    output logic             busy,
    output logic [7:0]       words_sent,
    output logic [2:0]       dbg_state
);

    // bit_cnt counts 0 (start bit) .. WIDTH (last data bit)
    localparam int              BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH);
    localparam logic [7:0]      CPB_LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_STOP = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               tx_q, tx_d;
    logic               fifo_re_q, fifo_re_d;
    logic               busy_q, busy_d;
    logic [7:0]         words_q, words_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]         clk_cnt_q, clk_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            fifo_re_q <= 1'b0;
            busy_q    <= 1'b0;
            words_q   <= 8'd0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            clk_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            fifo_re_q <= fifo_re_d;
            busy_q    <= busy_d;
            words_q   <= words_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            clk_cnt_q <= clk_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        fifo_re_d = 1'b0;
        words_d   = words_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        clk_cnt_d = clk_cnt_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (enable && !fifo_empty) begin
                    state_d   = S_REQ;
                    fifo_re_d = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // fifo_data is valid now; the start bit goes out on the same edge
                shift_d   = fifo_data;
                tx_d      = 1'b0;
                bit_cnt_d = '0;
                clk_cnt_d = 8'd0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (clk_cnt_q == CPB_LAST) begin
                    clk_cnt_d = 8'd0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // next data bit comes from the bottom of the shifter
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CPB_LAST) begin
                    clk_cnt_d = 8'd0;
                    words_d   = words_q + 8'd1;
                    state_d   = S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Registered so busy tracks state_q without a decode after the flop
    always_comb begin
        busy_d = (state_d != S_IDLE);
    end

    assign tx         = tx_q;
    assign fifo_re    = fifo_re_q;
    assign busy       = busy_q;
    assign words_sent = words_q;
    assign dbg_state  = state_q;

endmodule
